// File: rtl/jk_mod_counter_pkg.sv
// Shared definitions for the JK-based modulo counter.
// - jk_cmd_e : {j,k} command encodings applied to each JK cell
// - max_count: terminal (MODULO-1) value for a given modulus
package jk_mod_counter_pkg;

    // Encoded as {j, k} so a command can be assigned straight onto the cell inputs.
    typedef enum logic [1:0] {
        JkHold = 2'b00,
        JkClr  = 2'b01,
        JkSet  = 2'b10,
        JkTgl  = 2'b11
    } jk_cmd_e;

    localparam int unsigned DEFAULT_MODULO = 10;

    function automatic int unsigned max_count(input int unsigned modulo);
        return modulo - 1;
    endfunction

endpackage

// File: rtl/jk_mod_counter_jk_cell.sv
// One-bit JK flip-flop, posedge clocked, asynchronous active-high reset to 0.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset (q=0)
//   j, k - JK inputs: 00 hold, 01 clear, 10 set, 11 toggle
//   q    - stored bit
//   qbar - complement of q (valid during reset as well)
module jk_cell
    import jk_mod_counter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic j,
    input  logic k,
    output logic q,
    output logic qbar
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= 1'b0;
        end else begin
            unique case (jk_cmd_e'({j, k}))
                JkHold:  q <= q;
                JkClr:   q <= 1'b0;
                JkSet:   q <= 1'b1;
                JkTgl:   q <= ~q;
                default: q <= q;
            endcase
        end
    end

    assign qbar = ~q;

endmodule

// File: rtl/jk_mod_counter.sv
// Synchronous modulo-MODULO up/down counter built from WIDTH JK cells.
// Parameters:
//   WIDTH  - counter width (2..8)
//   MODULO - modulus N (2..2^WIDTH); count sequence is 0..N-1
// Ports:
//   clk       - rising-edge clock
//   rst       - asynchronous active-high reset (q=0, wrap_flag=0)
//   en        - count enable
//   up        - direction, 1 = increment, 0 = decrement
//   load      - synchronous parallel load (priority over en)
//   load_val  - load value, clamped to MODULO-1 when out of range
//   clr_flag  - synchronous clear of wrap_flag (a coincident wrap wins)
//   q, qbar   - current count and its complement
//   tc        - combinational terminal count: the next edge wraps
//   wrap_flag - sticky flag set on every modulo wrap
module jk_mod_counter
    import jk_mod_counter_pkg::*;
#(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned MODULO = DEFAULT_MODULO
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_flag,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             tc,
    output logic             wrap_flag
);

    localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(max_count(MODULO));

    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic             at_max;
    logic             at_zero;

    assign at_max  = (q == MAX_CNT);
    assign at_zero = (q == '0);

    // Per-bit steering: every transition is expressed as a JK command so the
    // cells never see anything but hold/clear/set/toggle.
    always_comb begin
        logic             ones_below;
        logic             zeros_below;
        logic [WIDTH-1:0] ld_val;
        jk_cmd_e          cmd;

        j           = '0;
        k           = '0;
        ones_below  = 1'b1;
        zeros_below = 1'b1;
        cmd         = JkHold;
        ld_val      = (32'(load_val) >= MODULO) ? MAX_CNT : load_val;

        for (int i = 0; i < WIDTH; i++) begin
            cmd = JkHold;
            if (load) begin
                cmd = ld_val[i] ? JkSet : JkClr;
            end else if (en) begin
                if (up) begin
                    // At MAX the wrap clears every bit; for a full binary
                    // modulus this coincides with the toggle rule.
                    if (at_max) begin
                        cmd = JkClr;
                    end else if (ones_below) begin
                        cmd = JkTgl;
                    end
                end else begin
                    if (at_zero) begin
                        cmd = MAX_CNT[i] ? JkSet : JkClr;
                    end else if (zeros_below) begin
                        cmd = JkTgl;
                    end
                end
            end
            {j[i], k[i]} = cmd;
            ones_below   = ones_below & q[i];
            zeros_below  = zeros_below & ~q[i];
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        jk_cell u_cell (
            .clk  (clk),
            .rst  (rst),
            .j    (j[i]),
            .k    (k[i]),
            .q    (q[i]),
            .qbar (qbar[i])
        );
    end

    assign tc = en & ~load & ((up & at_max) | (~up & at_zero));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrap_flag <= 1'b0;
        end else if (tc) begin
            wrap_flag <= 1'b1;
        end else if (clr_flag) begin
            wrap_flag <= 1'b0;
        end
    end

endmodule

// File: tb/tb_jk_mod_counter.sv
// Scoreboard bench: two counters (4-bit mod 10 and 3-bit mod 8) share one
// stimulus stream; a driver pushes expected results from an arithmetic model
// and a monitor pops and compares them each cycle.
module tb_jk_mod_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       en, up, load, clr_flag;
    logic [3:0] load_val;

    logic [3:0] q4, qbar4;
    logic       tc4, w4;
    logic [2:0] q3, qbar3;
    logic       tc3, w3;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        bit tc4;
        bit tc3;
        int q4;
        int q3;
        bit w4;
        bit w3;
    } exp_t;

    exp_t sb[$];

    int m4_q, m3_q;
    bit m4_w, m3_w;

    always #5 clk = ~clk;

    jk_mod_counter #(.WIDTH(4), .MODULO(10)) u_dut4 (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .up        (up),
        .load      (load),
        .load_val  (load_val),
        .clr_flag  (clr_flag),
        .q         (q4),
        .qbar      (qbar4),
        .tc        (tc4),
        .wrap_flag (w4)
    );

    jk_mod_counter #(.WIDTH(3), .MODULO(8)) u_dut3 (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .up        (up),
        .load      (load),
        .load_val  (load_val[2:0]),
        .clr_flag  (clr_flag),
        .q         (q3),
        .qbar      (qbar3),
        .tc        (tc3),
        .wrap_flag (w3)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit model_tc(input int cur, input bit e, input bit u, input bit l,
                                    input int n);
        return e && !l && (u ? (cur == n - 1) : (cur == 0));
    endfunction

    function automatic int model_next(input int cur, input bit e, input bit u, input bit l,
                                      input int lv, input int n);
        if (l) return (lv >= n) ? n - 1 : lv;
        if (e) return u ? (cur + 1) % n : (cur + n - 1) % n;
        return cur;
    endfunction

    task automatic step(input bit e, input bit u, input bit l, input int lv, input bit c);
        exp_t x;
        @(negedge clk);
        en       = e;
        up       = u;
        load     = l;
        load_val = lv[3:0];
        clr_flag = c;
        x.tc4 = model_tc(m4_q, e, u, l, 10);
        x.tc3 = model_tc(m3_q, e, u, l, 8);
        x.q4  = model_next(m4_q, e, u, l, lv % 16, 10);
        x.q3  = model_next(m3_q, e, u, l, lv % 8, 8);
        x.w4  = x.tc4 ? 1'b1 : (c ? 1'b0 : m4_w);
        x.w3  = x.tc3 ? 1'b1 : (c ? 1'b0 : m3_w);
        m4_q = x.q4;
        m3_q = x.q3;
        m4_w = x.w4;
        m3_w = x.w3;
        sb.push_back(x);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_q4"}, int'(q4), 0);
        chk({tag, "_qbar4"}, int'(qbar4), 15);
        chk({tag, "_w4"}, int'(w4), 0);
        chk({tag, "_q3"}, int'(q3), 0);
        chk({tag, "_qbar3"}, int'(qbar3), 7);
        chk({tag, "_w3"}, int'(w3), 0);
    endtask

    // Monitor: tc is checked mid low-phase (inputs settled, before the edge),
    // registered outputs just after the edge.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() != 0) begin
                x = sb.pop_front();
                chk("tc4", int'(tc4), int'(x.tc4));
                chk("tc3", int'(tc3), int'(x.tc3));
                @(posedge clk);
                #1;
                chk("q4", int'(q4), x.q4);
                chk("qbar4", int'(qbar4), (~x.q4) & 15);
                chk("wrap4", int'(w4), int'(x.w4));
                chk("q3", int'(q3), x.q3);
                chk("qbar3", int'(qbar3), (~x.q3) & 7);
                chk("wrap3", int'(w3), int'(x.w3));
            end
        end
    end

    initial begin
        int waited;
        rst = 1'b1;
        en = 0; up = 0; load = 0; load_val = 0; clr_flag = 0;
        m4_q = 0; m3_q = 0; m4_w = 0; m3_w = 0;
        #1;
        chk_reset_state("por");
        @(negedge clk);
        rst = 1'b0;

        // Count up through the mod-10 wrap.
        for (int i = 0; i < 12; i++) step(1, 1, 0, 0, 0);

        // Load 4, count down through 0->9 with clr_flag on the wrap edge.
        step(0, 0, 1, 4, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);

        // Out-of-range load with en also high: load wins and clamps.
        step(1, 1, 1, 13, 0);

        // Hold at 6 with up toggling, then resume.
        step(0, 0, 1, 6, 0);
        for (int i = 0; i < 5; i++) step(0, i[0], 0, 0, 0);
        step(1, 1, 0, 0, 0);

        // Asynchronous reset mid-cycle with a load in flight.
        @(negedge clk);
        en = 1; up = 1; load = 1; load_val = 4'd3;
        #3;
        rst = 1'b1;
        #1;
        chk_reset_state("arst");
        @(negedge clk);
        chk_reset_state("arst_hold");
        rst = 1'b0;
        en = 0; load = 0; load_val = 0;
        m4_q = 0; m3_q = 0; m4_w = 0; m3_w = 0;
        step(1, 1, 0, 0, 0);

        // Long up and down runs to cover natural 3-bit rollover both ways.
        for (int i = 0; i < 20; i++) step(1, 1, 0, 0, 0);
        for (int i = 0; i < 20; i++) step(1, 0, 0, 0, 0);

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(3, 0) != 0, $urandom_range(1, 0) == 1,
                 $urandom_range(9, 0) == 0, int'($urandom_range(15, 0)),
                 $urandom_range(7, 0) == 0);
        end

        waited = 0;
        while (sb.size() != 0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk("scoreboard_drained", sb.size(), 0);
        @(posedge clk);
        #3;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/jk_mod_counter.md
Name: jk_mod_counter

Overview:
Synchronous modulo-N up/down counter built from JK flip-flop cells. Each bit is a JK cell whose j/k inputs come from next-state steering logic. It consumes the JK storage behaviour of the lab's flip-flop stage and adds async reset, parallel load, direction control, terminal count and a sticky wrap flag. It is the counter stage for the sequential-circuit lab. Its outputs drive display/compare logic downstream.

Parameters:
WIDTH, 4, counter bit width (2..8)
MODULO, 10, count modulus N; legal range 2..2^WIDTH; count sequence is 0..N-1

Ports:
clk  input  1  rising-edge clock; the only clock
rst  input  1  asynchronous, active-high reset
en  input  1  count enable
up  input  1  direction: 1 = increment, 0 = decrement
load  input  1  synchronous parallel load
load_val  input  WIDTH  value applied on load
clr_flag  input  1  synchronous clear of wrap_flag
q  output  WIDTH  current count
qbar  output  WIDTH  bitwise complement of q
tc  output  1  terminal count (combinational)
wrap_flag  output  1  sticky; set on any modulo wrap

Behaviour:
- Reset: rst high forces q=0, qbar=all ones and wrap_flag=0 immediately, independent of clk. Reset is held while rst is high. First update occurs on the first rising clk after rst deasserts.
- Storage: every q bit is a JK cell with posedge update. Cell truth table: j=0,k=0 hold; j=0,k=1 clear; j=1,k=0 set; j=1,k=1 toggle.
- Priority per rising edge: load > en > hold.
- Load: q <= load_val. The value is applied through j=d, k=~d per bit. If load_val >= MODULO, q <= MODULO-1 (clamp). Load never sets wrap_flag.
- Count up (en=1, up=1):
  - Bit i toggles (j=k=1) when all lower bits are 1.
  - If q==MODULO-1, all bits clear instead (j=0,k=1) and q becomes 0. This is a wrap.
- Count down (en=1, up=0):
  - Bit i toggles when all lower bits are 0.
  - If q==0, q <= MODULO-1 via per-bit set/clear. This is a wrap.
- Hold: en=0 and load=0 give j=k=0 on all bits; q is unchanged.
- Latency: q reflects a load or count on the same rising edge where the control was sampled (one-cycle register latency).
- tc = en & ~load & ((up & q==MODULO-1) | (~up & q==0)). tc is combinational and valid in the cycle before the wrap edge.
- wrap_flag: registered. It is set on the edge where a wrap occurs (edge taken with tc=1).
  - clr_flag clears it on the edge.
  - Simultaneous wrap and clr_flag: the set wins and wrap_flag stays 1.
- Direction change mid-count: takes effect on the next edge, with no glitch or skipped state.
- Reset mid-count: the async clear overrides any in-flight load/count. wrap_flag is cleared.
- State space: q never leaves 0..MODULO-1 after reset, under any input sequence.
- When MODULO==2^WIDTH, wrap is natural binary rollover; the steering logic must give identical results to the toggle rule.
- qbar is always exactly ~q, including during reset.

Decomposition:
- Shared package/header: JK command encodings (HOLD=2'b00, CLR=2'b01, SET=2'b10, TGL=2'b11) and the MODULO-1 constant.
- Sub-module jk_cell: one-bit JK flip-flop with ports clk, rst, j, k, q, qbar, async active-high reset to 0. Instantiate it WIDTH times with a generate loop.
- Top level holds the steering logic, tc and the wrap_flag register.

Test Plan:
- Reset, then en=1, up=1 for 12 cycles (MODULO=10) -> q = 1,2,…,9,0,1,2; tc=1 only while q=9; wrap_flag rises on the 9->0 edge and stays 1.
- Load load_val=4, then up=0, en=1 for 6 cycles -> q = 4,3,2,1,0,9,8; tc=1 while q=0; clr_flag pulsed on the 0->9 edge leaves wrap_flag=1 (set wins), and a later clr_flag alone clears it to 0.
- load=1 with load_val=13 and en=1 in the same cycle -> q=9 (clamp, load priority); wrap_flag unchanged; tc=0 that cycle.
- At q=6, en=0 for 5 cycles with up toggling -> q stays 6, tc=0; re-enable with up=1 -> 7.
- Assert rst asynchronously mid-cycle at q=7 with load active -> q=0, qbar=4'hF and wrap_flag=0 before the next edge; counting resumes from 0 after release.
- Sweep WIDTH=3, MODULO=8 over 20 cycles in up and down modes -> natural rollover 7->0 and 0->7, tc/wrap_flag behave as above, and q never exceeds 7.
